multicycle_cpu: RTL and testbench
=================================

MULTICYCLE_CPU -- requirements
Module: multicycle_cpu

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 16, 32, 64.
REQ-002 SHALL have parameter NREG, default 32, register count; legal values 8, 16, 32; register fields index by the low log2(NREG) bits.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 instr_valid  in  1  instruction offered.
REQ-006 instr  in  32  MIPS-format instruction word.
REQ-007 instr_ready  out  1  core accepts an instruction this cycle.
REQ-008 dmem_req  out  1  data memory request, held until ack.
REQ-009 dmem_we  out  1  1 = store, 0 = load.
REQ-010 dmem_addr  out  XLEN  byte address.
REQ-011 dmem_wdata  out  XLEN  store data.
REQ-012 dmem_rdata  in  XLEN  load data, valid when dmem_ack = 1.
REQ-013 dmem_ack  in  1  request completes this cycle.
REQ-014 alu_result  out  XLEN  registered ALU output of the last EXEC.
REQ-015 zero  out  1  registered flag: alu_result == 0.
REQ-016 retire  out  1  one-cycle pulse per completed instruction.
REQ-017 illegal  out  1  one-cycle pulse on an unsupported opcode or funct.

Function
REQ-018 SHALL implement FSM states IDLE, DECODE, EXEC, MEM, WB.
REQ-019 instr_ready SHALL be 1 only in IDLE.
REQ-020 Accept = instr_valid & instr_ready at cycle T; instr latched; DECODE at T+1; EXEC at T+2.
REQ-021 Supported R-type (opcode 0x00) funct codes SHALL be add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A; writeback goes to rd.
REQ-022 Supported I-type opcodes SHALL be addi 0x08, lw 0x23, sw 0x2B, beq 0x04; addi and lw write back to rt.
REQ-023 imm16 SHALL be sign-extended to XLEN; add/sub/addi wrap modulo 2^XLEN; slt is a signed compare giving 1 or 0.
REQ-024 R-type/addi path SHALL be EXEC -> WB -> IDLE, with retire and register write in WB at T+3.
REQ-025 beq SHALL compute rs - rt in EXEC, update zero, pulse retire in EXEC, return to IDLE, and perform no write.
REQ-026 lw/sw SHALL compute dmem_addr = rs + sext(imm) in EXEC, then enter MEM with dmem_req = 1; dmem_addr, dmem_we and dmem_wdata (= rt) stay stable until dmem_ack.
REQ-027 In MEM with dmem_ack = 0, the FSM SHALL remain in MEM indefinitely.
REQ-028 sw with ack SHALL pulse retire in that cycle and go to IDLE.
REQ-029 lw with ack SHALL capture dmem_rdata and go to WB, writing rt and pulsing retire there.
REQ-030 An ack arriving in the same cycle as the request is raised (first MEM cycle) SHALL be legal.
REQ-031 An illegal opcode or funct SHALL pulse illegal in DECODE, return to IDLE, and produce no retire and no write.
REQ-032 Register 0 SHALL read 0; writes to it SHALL be discarded.
REQ-033 Register reads SHALL occur in DECODE, so a following instruction observes all prior writebacks (no hazards, since only one instruction is in flight).
REQ-034 alu_result and zero SHALL update only in EXEC and hold otherwise.

Reset
REQ-035 rst = 1 SHALL immediately force IDLE, clear all registers, alu_result = 0, zero = 0, and dmem_req/dmem_we/retire/illegal = 0.
REQ-036 Reset during MEM SHALL drop dmem_req asynchronously; the in-flight instruction is discarded with no retire.
REQ-037 After rst deasserts, instr_ready SHALL be 1 on the first clock.

Structure
REQ-038 Opcode/funct constants, ALU control codes and the FSM state encoding SHALL live in the shared package cpu_pkg.
REQ-039 The register file SHALL be the sub-module cpu_regfile (NREG x XLEN, two combinational read ports, one synchronous write port, asynchronous clear).
REQ-040 The existing ALU-control decode SHALL be reused via cpu_pkg; no other sub-modules.

Verification
REQ-041 addi r1,r0,5 then addi r2,r0,-3 then add r3,r1,r2 -> alu_result 2, retire at T+3 each, zero 0.
REQ-042 sub r4,r1,r1 -> alu_result 0, zero 1; slt r5,r2,r1 (-3 < 5) -> alu_result 1.
REQ-043 sw r1,8(r0) with ack delayed 3 cycles -> dmem_req held 4 cycles, addr 8, wdata 5, we 1, retire on the ack cycle; lw r6,8(r0) returning rdata 5 -> r6 = 5, retire in WB.
REQ-044 Opcode 0x3F, then R-type funct 0x00 -> illegal pulses in DECODE, no retire, register file unchanged; addi r0,r0,7 -> r0 reads 0.
REQ-045 rst asserted mid-MEM of lw -> dmem_req 0 within the same cycle, no retire, all registers 0, instr_ready 1 on the first clock after release.
REQ-046 XLEN = 16: addi r1,r0,0x7FFF then addi r1,r1,1 -> alu_result 0x8000 (wrap); NREG = 8: rd = 9 writes r1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared ISA constants, ALU control codes, FSM encoding and the opcode/funct decode
// used by the multicycle core.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_e;

  typedef struct packed {
    logic    legal;
    alu_op_e alu_op;
    logic    use_imm;
    logic    reg_write;
    logic    dst_rt;
    logic    is_load;
    logic    is_store;
    logic    is_branch;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [5:0] opcode, input logic [5:0] funct);
    ctrl_t c;
    c = '0;
    c.alu_op = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        c.legal     = 1'b1;
        c.reg_write = 1'b1;
        case (funct)
          FN_ADD:  c.alu_op = ALU_ADD;
          FN_SUB:  c.alu_op = ALU_SUB;
          FN_AND:  c.alu_op = ALU_AND;
          FN_OR:   c.alu_op = ALU_OR;
          FN_SLT:  c.alu_op = ALU_SLT;
          default: begin
            c.legal     = 1'b0;
            c.reg_write = 1'b0;
          end
        endcase
      end
      OP_ADDI: begin
        c.legal     = 1'b1;
        c.use_imm   = 1'b1;
        c.reg_write = 1'b1;
        c.dst_rt    = 1'b1;
      end
      OP_LW: begin
        c.legal     = 1'b1;
        c.use_imm   = 1'b1;
        c.reg_write = 1'b1;
        c.dst_rt    = 1'b1;
        c.is_load   = 1'b1;
      end
      OP_SW: begin
        c.legal    = 1'b1;
        c.use_imm  = 1'b1;
        c.is_store = 1'b1;
      end
      OP_BEQ: begin
        c.legal     = 1'b1;
        c.alu_op    = ALU_SUB;
        c.is_branch = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// NREG x XLEN register file: two combinational read ports, one synchronous write port,
// register 0 hardwired to zero, asynchronous clear.
module cpu_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   i_ra,
  input  logic [AW-1:0]   i_rb,
  output logic [XLEN-1:0] o_rd_a,
  output logic [XLEN-1:0] o_rd_b,
  input  logic            i_we,
  input  logic [AW-1:0]   i_wa,
  input  logic [XLEN-1:0] i_wd
);

  logic [XLEN-1:0] r_regs [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (i_we && (i_wa != '0)) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  assign o_rd_a = (i_ra == '0) ? '0 : r_regs[i_ra];
  assign o_rd_b = (i_rb == '0) ? '0 : r_regs[i_rb];

endmodule

// File: rtl/multicycle_cpu.sv
// Multicycle MIPS-subset core: IDLE -> DECODE -> EXEC -> (MEM) -> (WB), one instruction
// in flight; data memory uses a req/ack handshake held in MEM until acknowledged.
module multicycle_cpu
  import cpu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  output logic            instr_ready,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ack,
  output logic [XLEN-1:0] alu_result,
  output logic            zero,
  output logic            retire,
  output logic            illegal
);

  localparam int AW = $clog2(NREG);

  state_e          r_state;
  state_e          w_next;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_rs_val;
  logic [XLEN-1:0] r_rt_val;
  logic [XLEN-1:0] r_alu_result;
  logic            r_zero;
  logic [XLEN-1:0] r_mem_data;

  ctrl_t           w_ctrl;
  logic [AW-1:0]   w_rs_idx;
  logic [AW-1:0]   w_rt_idx;
  logic [AW-1:0]   w_rd_idx;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_op_b;
  logic [XLEN-1:0] w_alu;
  logic [XLEN-1:0] w_rf_a;
  logic [XLEN-1:0] w_rf_b;
  logic            w_rf_we;
  logic [AW-1:0]   w_rf_wa;
  logic [XLEN-1:0] w_rf_wd;
  logic            w_unused;

  // Register fields use only the low log2(NREG) bits of each 5-bit MIPS field.
  assign w_ctrl   = decode_ctrl(r_instr[31:26], r_instr[5:0]);
  assign w_rs_idx = r_instr[21 +: AW];
  assign w_rt_idx = r_instr[16 +: AW];
  assign w_rd_idx = r_instr[11 +: AW];
  assign w_imm    = XLEN'($signed(r_instr[15:0]));
  assign w_op_b   = w_ctrl.use_imm ? w_imm : r_rt_val;
  assign w_unused = ^r_instr;

  always_comb begin
    w_alu = '0;
    case (w_ctrl.alu_op)
      ALU_ADD: w_alu = r_rs_val + w_op_b;
      ALU_SUB: w_alu = r_rs_val - w_op_b;
      ALU_AND: w_alu = r_rs_val & w_op_b;
      ALU_OR:  w_alu = r_rs_val | w_op_b;
      ALU_SLT: w_alu[0] = ($signed(r_rs_val) < $signed(w_op_b));
      default: w_alu = '0;
    endcase
  end

  assign w_rf_we = (r_state == S_WB) && w_ctrl.reg_write;
  assign w_rf_wa = w_ctrl.dst_rt ? w_rt_idx : w_rd_idx;
  assign w_rf_wd = w_ctrl.is_load ? r_mem_data : r_alu_result;

  cpu_regfile #(
    .XLEN(XLEN),
    .NREG(NREG)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .i_ra   (w_rs_idx),
    .i_rb   (w_rt_idx),
    .o_rd_a (w_rf_a),
    .o_rd_b (w_rf_b),
    .i_we   (w_rf_we),
    .i_wa   (w_rf_wa),
    .i_wd   (w_rf_wd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (instr_valid) w_next = S_DECODE;
      S_DECODE: w_next = w_ctrl.legal ? S_EXEC : S_IDLE;
      S_EXEC: begin
        if (w_ctrl.is_branch)                      w_next = S_IDLE;
        else if (w_ctrl.is_load || w_ctrl.is_store) w_next = S_MEM;
        else                                       w_next = S_WB;
      end
      S_MEM:    if (dmem_ack) w_next = w_ctrl.is_load ? S_WB : S_IDLE;
      S_WB:     w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Operands are sampled in DECODE; the EXEC result doubles as the memory address in MEM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr      <= '0;
      r_rs_val     <= '0;
      r_rt_val     <= '0;
      r_alu_result <= '0;
      r_zero       <= 1'b0;
      r_mem_data   <= '0;
    end else begin
      if (r_state == S_IDLE && instr_valid) r_instr <= instr;
      if (r_state == S_DECODE) begin
        r_rs_val <= w_rf_a;
        r_rt_val <= w_rf_b;
      end
      if (r_state == S_EXEC) begin
        r_alu_result <= w_alu;
        r_zero       <= (w_alu == '0);
      end
      if (r_state == S_MEM && dmem_ack && w_ctrl.is_load) r_mem_data <= dmem_rdata;
    end
  end

  assign instr_ready = (r_state == S_IDLE);
  assign illegal     = (r_state == S_DECODE) && !w_ctrl.legal;
  assign retire      = (r_state == S_WB)
                     || ((r_state == S_EXEC) && w_ctrl.is_branch)
                     || ((r_state == S_MEM) && dmem_ack && w_ctrl.is_store);
  assign dmem_req    = (r_state == S_MEM);
  assign dmem_we     = (r_state == S_MEM) && w_ctrl.is_store;
  assign dmem_addr   = r_alu_result;
  assign dmem_wdata  = r_rt_val;
  assign alu_result  = r_alu_result;
  assign zero        = r_zero;

endmodule

// File: tb/tb_multicycle_cpu.sv
// Randomized bench for multicycle_cpu against an instruction-level reference model;
// a second 16-bit / 8-register instance covers wrap-around and field truncation.
module tb_multicycle_cpu;

  localparam int K_ALU = 0;
  localparam int K_BEQ = 1;
  localparam int K_LW  = 2;
  localparam int K_SW  = 3;
  localparam int K_ILL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic [31:0] alu_result;
  logic        zero;
  logic        retire;
  logic        illegal;

  logic        v16;
  logic [31:0] i16;
  logic        rdy16;
  logic        req16_unused;
  logic        we16_unused;
  logic [15:0] addr16_unused;
  logic [15:0] wdata16_unused;
  logic [15:0] alu16;
  logic        zero16;
  logic        ret16;
  logic        ill16_unused;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_alu;
  logic [31:0] m_mem [logic [31:0]];

  always #5 clk = ~clk;

  multicycle_cpu #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .alu_result(alu_result), .zero(zero),
    .retire(retire), .illegal(illegal)
  );

  multicycle_cpu #(.XLEN(16), .NREG(8)) dut16 (
    .clk(clk), .rst(rst), .instr_valid(v16), .instr(i16), .instr_ready(rdy16),
    .dmem_req(req16_unused), .dmem_we(we16_unused), .dmem_addr(addr16_unused),
    .dmem_wdata(wdata16_unused), .dmem_rdata(16'h0), .dmem_ack(1'b0), .alu_result(alu16),
    .zero(zero16), .retire(ret16), .illegal(ill16_unused)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] r_type(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_alu = '0;
  endtask

  // Issue one instruction and check every cycle of its execution against the ISA model.
  task automatic run_instr(input logic [31:0] ins, input int ack_dly);
    logic [5:0]  op;
    logic [5:0]  fn;
    int          rs, rt, wr, kind;
    logic [31:0] a, b, imm, res;
    op = ins[31:26];
    fn = ins[5:0];
    rs = int'(ins[25:21]);
    rt = int'(ins[20:16]);
    wr = int'(ins[15:11]);
    a = m_regs[rs];
    b = m_regs[rt];
    imm = {{16{ins[15]}}, ins[15:0]};
    res = '0;
    kind = K_ALU;
    case (op)
      6'h00: case (fn)
        6'h20: res = a + b;
        6'h22: res = a - b;
        6'h24: res = a & b;
        6'h25: res = a | b;
        6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        default: kind = K_ILL;
      endcase
      6'h08: begin res = a + imm; wr = rt; end
      6'h23: begin res = a + imm; wr = rt; kind = K_LW; end
      6'h2B: begin res = a + imm; kind = K_SW; end
      6'h04: begin res = a - b; kind = K_BEQ; end
      default: kind = K_ILL;
    endcase

    @(negedge clk);
    chk("ready", instr_ready, 1'b1);
    instr_valid = 1'b1;
    instr = ins;
    @(negedge clk);
    instr_valid = 1'b0;
    instr = $urandom;
    chk("illegal_dec", illegal, kind == K_ILL);
    chk("retire_dec", retire, 1'b0);
    chk("alu_hold", alu_result, m_alu);
    if (kind == K_ILL) return;
    @(negedge clk);
    chk("retire_exec", retire, kind == K_BEQ);
    chk("req_exec", dmem_req, 1'b0);
    m_alu = res;
    @(negedge clk);
    chk("alu", alu_result, res);
    chk("zero", zero, res == 0);
    if (kind == K_ALU || kind == K_BEQ) begin
      chk("retire_post", retire, kind == K_ALU);
      if (kind == K_ALU && wr != 0) m_regs[wr] = res;
      return;
    end
    if (kind == K_LW && !m_mem.exists(res)) m_mem[res] = $urandom;
    for (int c = 0; c <= ack_dly; c++) begin
      if (c > 0) @(negedge clk);
      dmem_ack = (c == ack_dly);
      dmem_rdata = (c == ack_dly && kind == K_LW) ? m_mem[res] : $urandom;
      #1;
      chk("mem_req", dmem_req, 1'b1);
      chk("mem_addr", dmem_addr, res);
      chk("mem_we", dmem_we, kind == K_SW);
      if (kind == K_SW) chk("mem_wdata", dmem_wdata, b);
      chk("retire_mem", retire, (kind == K_SW) && (c == ack_dly));
    end
    @(negedge clk);
    dmem_ack = 1'b0;
    chk("req_after", dmem_req, 1'b0);
    chk("retire_after", retire, kind == K_LW);
    if (kind == K_LW && wr != 0) m_regs[wr] = m_mem[res];
    if (kind == K_SW) m_mem[res] = b;
  endtask

  // add r0, ri, r0 exposes ri on alu_result without modifying architectural state.
  task automatic probe_regs(input int n);
    for (int i = 0; i < n; i++) run_instr(r_type(i, 0, 0, 6'h20), 0);
  endtask

  function automatic logic [31:0] rand_instr();
    int          sel;
    int          rs, rt, rd;
    logic [5:0]  op;
    logic [5:0]  fns [5];
    sel = int'($urandom_range(0, 9));
    rs = int'($urandom_range(0, 7));
    rt = int'($urandom_range(0, 7));
    rd = int'($urandom_range(0, 7));
    fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25; fns[4] = 6'h2A;
    case (sel)
      0, 1, 2: return i_type(6'h08, rs, rt, 16'($urandom));
      3, 4, 5: return r_type(rs, rt, rd, fns[$urandom_range(0, 4)]);
      6:       return i_type(6'h23, rs, rt, 16'($urandom));
      7:       return i_type(6'h2B, rs, rt, 16'($urandom));
      8:       return i_type(6'h04, rs, rt, 16'($urandom));
      default: begin
        op = 6'($urandom);
        if (op == 6'h00 || op == 6'h08 || op == 6'h23 || op == 6'h2B || op == 6'h04) op = 6'h3F;
        return ($urandom_range(0, 1) == 0) ? {op, 26'($urandom)} : r_type(rs, rt, rd, 6'h00);
      end
    endcase
  endfunction

  task automatic issue16(input string tag, input logic [31:0] ins, input logic [15:0] exp);
    @(negedge clk);
    chk("ready16", rdy16, 1'b1);
    v16 = 1'b1;
    i16 = ins;
    @(negedge clk);
    v16 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("retire16", ret16, 1'b1);
    chk(tag, alu16, exp);
    chk("zero16", zero16, exp == 0);
  endtask

  initial begin
    rst = 1'b1;
    instr_valid = 1'b0;
    instr = '0;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    v16 = 1'b0;
    i16 = '0;
    model_reset();
    #12;
    chk("rst_alu", alu_result, 32'h0);
    chk("rst_zero", zero, 1'b0);
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_we", dmem_we, 1'b0);
    chk("rst_retire", retire, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    run_instr(i_type(6'h08, 0, 1, 16'd5), 0);
    run_instr(i_type(6'h08, 0, 2, 16'hFFFD), 0);
    run_instr(r_type(1, 2, 3, 6'h20), 0);
    run_instr(r_type(1, 1, 4, 6'h22), 0);
    run_instr(r_type(2, 1, 5, 6'h2A), 0);
    run_instr(i_type(6'h2B, 0, 1, 16'd8), 3);
    run_instr(i_type(6'h23, 0, 6, 16'd8), 1);
    run_instr(i_type(6'h23, 0, 7, 16'd8), 0);
    run_instr(i_type(6'h04, 1, 6, 16'd0), 0);
    run_instr({6'h3F, 26'h0}, 0);
    run_instr(r_type(1, 2, 7, 6'h00), 0);
    run_instr(i_type(6'h08, 0, 0, 16'd7), 0);
    probe_regs(8);

    for (int n = 0; n < 200; n++) run_instr(rand_instr(), int'($urandom_range(0, 3)));
    probe_regs(32);

    // Reset while a load is stalled in MEM.
    @(negedge clk);
    instr_valid = 1'b1;
    instr = i_type(6'h23, 0, 7, 16'd12);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("mid_mem_req", dmem_req, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mem_req", dmem_req, 1'b0);
    chk("rst_mem_retire", retire, 1'b0);
    chk("rst_mem_ready", instr_ready, 1'b1);
    chk("rst_mem_alu", alu_result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    chk("ready_after_rst", instr_ready, 1'b1);
    probe_regs(32);

    issue16("wrap_a", i_type(6'h08, 0, 1, 16'h7FFF), 16'h7FFF);
    issue16("wrap_b", i_type(6'h08, 1, 1, 16'h0001), 16'h8000);
    issue16("r2", i_type(6'h08, 0, 2, 16'h0003), 16'h0003);
    issue16("rd9", r_type(2, 2, 9, 6'h20), 16'h0006);
    issue16("probe_r1", r_type(1, 0, 0, 6'h20), 16'h0006);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
